capture_ctrl: RTL and testbench
===============================

CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning ADC sample width.
REQ-002 SHALL have parameter CNT_WIDTH, default 10, meaning post-trigger counter width.
REQ-003 SHALL have port clk_i  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port arm_i  input  1  one-cycle request to start a capture.
REQ-006 SHALL have port abort_i  input  1  cancel the capture and return to IDLE.
REQ-007 SHALL have port edge_i  input  1  trigger slope: 0 rising, 1 falling.
REQ-008 SHALL have port level_i  input  DATA_WIDTH  trigger threshold, unsigned.
REQ-009 SHALL have port post_cnt_i  input  CNT_WIDTH  samples to write per capture, including the trigger sample.
REQ-010 SHALL have port sample_i  input  DATA_WIDTH  ADC sample.
REQ-011 SHALL have port sample_valid_i  input  1  sample_i is valid this cycle.
REQ-012 SHALL have port fifo_full_i  input  1  full flag from the FIFO write-pointer block.
REQ-013 SHALL have port wr_data_o  output  DATA_WIDTH  data to the FIFO memory.
REQ-014 SHALL have port wr_inc_o  output  1  write strobe to the write-pointer inc input.
REQ-015 SHALL have port state_o  output  2  current state encoding.
REQ-016 SHALL have port triggered_o  output  1  high from trigger until the next arm, abort or reset.
REQ-017 SHALL have port done_o  output  1  one-cycle pulse when a capture completes.
REQ-018 SHALL have port overflow_o  output  1  sticky flag: a sample was dropped because the FIFO was full.

Function
REQ-019 SHALL implement the states IDLE=0, ARMED=1, CAPTURE=2 and DONE=3, and drive that encoding on state_o.
REQ-020 SHALL move IDLE->ARMED or DONE->ARMED on arm_i, latch post_cnt_i (0 treated as 1), and clear triggered_o, overflow_o and the previous-sample-valid flag.
REQ-021 SHALL ignore arm_i in ARMED and CAPTURE.
REQ-022 SHALL move any state to IDLE on abort_i, with no done_o pulse; abort_i wins over a simultaneous arm_i.
REQ-023 SHALL, in ARMED, detect a rising trigger when prev<level_i and sample_i>=level_i, and a falling trigger when prev>level_i and sample_i<=level_i, where prev is the last valid sample taken since arm.
REQ-024 SHALL NOT trigger on the first valid sample after arm.
REQ-025 SHALL count the trigger sample as the first capture sample; triggered_o and the CAPTURE state are set on the next edge.
REQ-026 SHALL, for each counted sample with fifo_full_i low, assert wr_inc_o for exactly one cycle on the cycle after sample_valid_i, with wr_data_o equal to that sample.
REQ-027 SHALL, for a counted sample with fifo_full_i high, drop the sample, set overflow_o, and still decrement the remaining count (keeps the time base).
REQ-028 SHALL go to DONE and pulse done_o in the cycle after the last counted sample, coincident with that sample's wr_inc_o.
REQ-029 SHALL hold wr_inc_o low in IDLE, ARMED and DONE, except for the final strobe of REQ-028.
REQ-030 SHALL never assert wr_inc_o while the sample's fifo_full_i was high.

Reset
REQ-031 SHALL, while rst_i is low at a clock edge, set state IDLE, wr_inc_o=0, wr_data_o=0, triggered_o=0, done_o=0, overflow_o=0, counter=0 and prev-valid=0.
REQ-032 SHALL, on reset mid-capture, emit no further strobes and no done_o pulse.

Structure
REQ-033 SHALL place the state encodings and the default widths in a shared package capture_pkg.
REQ-034 SHALL put slope and threshold compare plus prev-sample tracking in sub-module trigger_detect.

Verification
REQ-035 SHALL cover rising trigger: level=100, post=4, samples 50,90,120,130,140,150,160 -> triggers on 120; wr_inc_o strobes 120,130,140,150; one done_o; state DONE.
REQ-036 SHALL cover falling trigger: edge=1, level=100, samples 200,80 -> triggers on 80 (not on the first sample).
REQ-037 SHALL cover full FIFO: fifo_full_i high for the 2nd counted sample, post=4 -> 3 strobes, overflow_o=1, done_o after the 4th sample.
REQ-038 SHALL cover abort and arm together during CAPTURE -> IDLE next cycle, no done_o, no further wr_inc_o.
REQ-039 SHALL cover reset mid-CAPTURE (rst_i=0 for one cycle) -> all outputs 0, state IDLE; later arm_i re-arms normally.
REQ-040 SHALL cover post=0 -> exactly one strobe (the trigger sample), then done_o.

Source files
------------

// File: rtl/capture_pkg.sv
// Shared definitions for the capture controller: state encodings and default widths.
package capture_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int CNT_WIDTH_DEF  = 10;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_ARMED   = 2'd1;
    localparam state_t ST_CAPTURE = 2'd2;
    localparam state_t ST_DONE    = 2'd3;

endpackage

// File: rtl/trigger_detect.sv
// Slope/threshold trigger detector with previous-sample tracking.
module trigger_detect #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  track_i,
    input  logic                  edge_i,
    input  logic [DATA_WIDTH-1:0] level_i,
    input  logic [DATA_WIDTH-1:0] sample_i,
    input  logic                  sample_valid_i,
    output logic                  trig_o
);

    logic [DATA_WIDTH-1:0] prev_q, prev_d;
    logic                  prev_vld_q, prev_vld_d;
    logic                  rise_hit, fall_hit;

    // Next previous-sample value: cleared on arm, updated by each valid sample while tracking.
    always_comb begin
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        if (clear_i) begin
            prev_vld_d = 1'b0;
        end else if (track_i && sample_valid_i) begin
            prev_d     = sample_i;
            prev_vld_d = 1'b1;
        end
    end

    // Previous-sample registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
        end
    end

    assign rise_hit = (prev_q < level_i) && (sample_i >= level_i);
    assign fall_hit = (prev_q > level_i) && (sample_i <= level_i);

    // A trigger needs a prior valid sample, so the first sample after arm never fires.
    assign trig_o = track_i && sample_valid_i && prev_vld_q && (edge_i ? fall_hit : rise_hit);

endmodule

// File: rtl/capture_ctrl.sv
// Capture controller: arms on request, waits for a threshold crossing, then
// streams a fixed number of samples to the FIFO write port.
//
// state   | meaning
// IDLE    | waiting for arm
// ARMED   | watching samples for the trigger crossing
// CAPTURE | writing post-trigger samples, counting down
// DONE    | capture finished, waiting for re-arm
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  arm_i,
    input  logic                  abort_i,
    input  logic                  edge_i,
    input  logic [DATA_WIDTH-1:0] level_i,
    input  logic [CNT_WIDTH-1:0]  post_cnt_i,
    input  logic [DATA_WIDTH-1:0] sample_i,
    input  logic                  sample_valid_i,
    input  logic                  fifo_full_i,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic                  wr_inc_o,
    output logic [1:0]            state_o,
    output logic                  triggered_o,
    output logic                  done_o,
    output logic                  overflow_o
);

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  trig_q, trig_d;
    logic                  ovf_q, ovf_d;
    logic                  wr_inc_q, wr_inc_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  done_q, done_d;
    logic                  arm_accept;
    logic                  take;
    logic                  trig_hit;
    logic                  track;

    assign track = (state_q == ST_ARMED) && !abort_i;

    trigger_detect #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_trig (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .clear_i        (arm_accept),
        .track_i        (track),
        .edge_i         (edge_i),
        .level_i        (level_i),
        .sample_i       (sample_i),
        .sample_valid_i (sample_valid_i),
        .trig_o         (trig_hit)
    );

    // FSM next-state, remaining-sample down-counter and write strobe generation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        trig_d     = trig_q;
        ovf_d      = ovf_q;
        wr_inc_d   = 1'b0;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        arm_accept = 1'b0;
        take       = 1'b0;

        if (abort_i) begin
            state_d = ST_IDLE;
            trig_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm_i) begin
                        state_d    = ST_ARMED;
                        cnt_d      = (post_cnt_i == '0) ? CNT_WIDTH'(1) : post_cnt_i;
                        trig_d     = 1'b0;
                        ovf_d      = 1'b0;
                        arm_accept = 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (trig_hit) begin
                        take   = 1'b1;
                        trig_d = 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    take = sample_valid_i;
                end
                default: state_d = ST_IDLE;
            endcase

            // The trigger sample is the first counted one; a full FIFO drops
            // the sample but still consumes a count to keep the time base.
            if (take) begin
                cnt_d = cnt_q - CNT_WIDTH'(1);
                if (fifo_full_i) begin
                    ovf_d = 1'b1;
                end else begin
                    wr_inc_d  = 1'b1;
                    wr_data_d = sample_i;
                end
                if (cnt_q == CNT_WIDTH'(1)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
        end
    end

    // Controller registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            trig_q    <= 1'b0;
            ovf_q     <= 1'b0;
            wr_inc_q  <= 1'b0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            trig_q    <= trig_d;
            ovf_q     <= ovf_d;
            wr_inc_q  <= wr_inc_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
        end
    end

    assign state_o     = state_q;
    assign triggered_o = trig_q;
    assign overflow_o  = ovf_q;
    assign wr_inc_o    = wr_inc_q;
    assign wr_data_o   = wr_data_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed, table-driven bench for capture_ctrl.
module tb_capture_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       arm_i = 1'b0;
    logic       abort_i = 1'b0;
    logic       edge_i = 1'b0;
    logic [7:0] level_i = 8'd100;
    logic [9:0] post_cnt_i = 10'd4;
    logic [7:0] sample_i = 8'd0;
    logic       sample_valid_i = 1'b0;
    logic       fifo_full_i = 1'b0;
    logic [7:0] wr_data_o;
    logic       wr_inc_o;
    logic [1:0] state_o;
    logic       triggered_o;
    logic       done_o;
    logic       overflow_o;

    int n_cmp = 0;
    int n_err = 0;

    capture_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(10)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .arm_i          (arm_i),
        .abort_i        (abort_i),
        .edge_i         (edge_i),
        .level_i        (level_i),
        .post_cnt_i     (post_cnt_i),
        .sample_i       (sample_i),
        .sample_valid_i (sample_valid_i),
        .fifo_full_i    (fifo_full_i),
        .wr_data_o      (wr_data_o),
        .wr_inc_o       (wr_inc_o),
        .state_o        (state_o),
        .triggered_o    (triggered_o),
        .done_o         (done_o),
        .overflow_o     (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       rst;
        logic       arm;
        logic       abort;
        logic       edg;
        logic [7:0] level;
        logic [9:0] post;
        logic [7:0] smp;
        logic       vld;
        logic       full;
        logic       e_inc;
        logic [7:0] e_data;
        logic [1:0] e_st;
        logic       e_trg;
        logic       e_dn;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic rst, logic arm, logic abort, logic edg,
                               logic [7:0] level, logic [9:0] post, logic [7:0] smp,
                               logic vld, logic full, logic e_inc, logic [7:0] e_data,
                               logic [1:0] e_st, logic e_trg, logic e_dn, logic e_ovf);
        vec_t r;
        r.rst = rst; r.arm = arm; r.abort = abort; r.edg = edg;
        r.level = level; r.post = post; r.smp = smp; r.vld = vld; r.full = full;
        r.e_inc = e_inc; r.e_data = e_data; r.e_st = e_st;
        r.e_trg = e_trg; r.e_dn = e_dn; r.e_ovf = e_ovf;
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_row(int idx, vec_t r);
        chk($sformatf("row%0d wr_inc", idx), 32'(wr_inc_o), 32'(r.e_inc));
        chk($sformatf("row%0d state", idx), 32'(state_o), 32'(r.e_st));
        chk($sformatf("row%0d triggered", idx), 32'(triggered_o), 32'(r.e_trg));
        chk($sformatf("row%0d done", idx), 32'(done_o), 32'(r.e_dn));
        chk($sformatf("row%0d overflow", idx), 32'(overflow_o), 32'(r.e_ovf));
        if (r.e_inc || !r.rst)
            chk($sformatf("row%0d wr_data", idx), 32'(wr_data_o), 32'(r.e_data));
    endtask

    initial begin
        int strobes;
        int dones;
        bit seen_done;

        // reset
        vecs.push_back(v(0,0,0,0,100,4,  0,0,0, 0,  0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,100,4,  0,0,0, 0,  0,0,0,0,0));
        // rising trigger on 120, four strobes, arm ignored mid-capture
        vecs.push_back(v(1,1,0,0,100,4,  0,0,0, 0,  0,1,0,0,0));
        vecs.push_back(v(1,0,0,0,100,4, 50,1,0, 0,  0,1,0,0,0));
        vecs.push_back(v(1,0,0,0,100,4, 90,1,0, 0,  0,1,0,0,0));
        vecs.push_back(v(1,0,0,0,100,4,120,1,0, 1,120,2,1,0,0));
        vecs.push_back(v(1,0,0,0,100,4,130,1,0, 1,130,2,1,0,0));
        vecs.push_back(v(1,1,0,0,100,4,  0,0,0, 0,  0,2,1,0,0));
        vecs.push_back(v(1,0,0,0,100,4,140,1,0, 1,140,2,1,0,0));
        vecs.push_back(v(1,0,0,0,100,4,150,1,0, 1,150,3,1,1,0));
        vecs.push_back(v(1,0,0,0,100,4,160,1,0, 0,  0,3,1,0,0));
        // falling trigger from DONE, then abort+arm together in CAPTURE
        vecs.push_back(v(1,1,0,1,100,4,  0,0,0, 0,  0,1,0,0,0));
        vecs.push_back(v(1,0,0,1,100,4,200,1,0, 0,  0,1,0,0,0));
        vecs.push_back(v(1,0,0,1,100,4, 80,1,0, 1, 80,2,1,0,0));
        vecs.push_back(v(1,1,1,1,100,4, 70,1,0, 0,  0,0,0,0,0));
        vecs.push_back(v(1,0,0,1,100,4, 60,1,0, 0,  0,0,0,0,0));
        // full FIFO on the 2nd counted sample; trigger at exactly the level
        vecs.push_back(v(1,1,0,0,100,4,  0,0,0, 0,  0,1,0,0,0));
        vecs.push_back(v(1,1,0,0,100,4, 10,1,0, 0,  0,1,0,0,0));
        vecs.push_back(v(1,0,0,0,100,4,100,1,0, 1,100,2,1,0,0));
        vecs.push_back(v(1,0,0,0,100,4,110,1,1, 0,  0,2,1,0,1));
        vecs.push_back(v(1,0,0,0,100,4,120,1,0, 1,120,2,1,0,1));
        vecs.push_back(v(1,0,0,0,100,4,130,1,0, 1,130,3,1,1,1));
        vecs.push_back(v(1,0,0,0,100,4,  0,0,0, 0,  0,3,1,0,1));
        // post=0 behaves as one sample; prev equal to level must not trigger
        vecs.push_back(v(1,1,0,0,100,0,  0,0,0, 0,  0,1,0,0,0));
        vecs.push_back(v(1,0,0,0,100,0,100,1,0, 0,  0,1,0,0,0));
        vecs.push_back(v(1,0,0,0,100,0,150,1,0, 0,  0,1,0,0,0));
        vecs.push_back(v(1,0,0,0,100,0, 99,1,0, 0,  0,1,0,0,0));
        vecs.push_back(v(1,0,0,0,100,0,100,1,0, 1,100,3,1,1,0));
        vecs.push_back(v(1,0,0,0,100,0,200,1,0, 0,  0,3,1,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            rst_i          = vecs[i].rst;
            arm_i          = vecs[i].arm;
            abort_i        = vecs[i].abort;
            edge_i         = vecs[i].edg;
            level_i        = vecs[i].level;
            post_cnt_i     = vecs[i].post;
            sample_i       = vecs[i].smp;
            sample_valid_i = vecs[i].vld;
            fifo_full_i    = vecs[i].full;
            tick();
            check_row(i, vecs[i]);
        end

        // Abort during CAPTURE: no strobes or done afterwards despite crossings.
        arm_i = 1'b1; abort_i = 1'b0; edge_i = 1'b0; level_i = 8'd100; post_cnt_i = 10'd8;
        sample_valid_i = 1'b0; fifo_full_i = 1'b0;
        tick();
        arm_i = 1'b0;
        sample_i = 8'd50; sample_valid_i = 1'b1; tick();
        sample_i = 8'd120; tick();
        chk("abortseq capture state", 32'(state_o), 32'd2);
        abort_i = 1'b1; sample_i = 8'd130; tick();
        chk("abortseq state after abort", 32'(state_o), 32'd0);
        chk("abortseq wr_inc at abort", 32'(wr_inc_o), 32'd0);
        chk("abortseq triggered cleared", 32'(triggered_o), 32'd0);
        abort_i = 1'b0;
        strobes = 0; dones = 0;
        for (int i = 0; i < 6; i++) begin
            sample_i = (i % 2 == 0) ? 8'd40 : 8'd160;
            tick();
            strobes += int'(wr_inc_o);
            dones   += int'(done_o);
        end
        chk("abortseq strobes after abort", 32'(strobes), 32'd0);
        chk("abortseq done after abort", 32'(dones), 32'd0);
        chk("abortseq stays idle", 32'(state_o), 32'd0);

        // Reset mid-CAPTURE, then re-arm and run to completion within a budget.
        sample_valid_i = 1'b0; arm_i = 1'b1; post_cnt_i = 10'd4; tick();
        arm_i = 1'b0;
        sample_i = 8'd50; sample_valid_i = 1'b1; tick();
        sample_i = 8'd120; tick();
        chk("rstseq capture state", 32'(state_o), 32'd2);
        chk("rstseq first strobe", 32'(wr_inc_o), 32'd1);
        rst_i = 1'b0; sample_i = 8'd130; tick();
        chk("rstseq state", 32'(state_o), 32'd0);
        chk("rstseq wr_inc", 32'(wr_inc_o), 32'd0);
        chk("rstseq wr_data", 32'(wr_data_o), 32'd0);
        chk("rstseq triggered", 32'(triggered_o), 32'd0);
        chk("rstseq done", 32'(done_o), 32'd0);
        chk("rstseq overflow", 32'(overflow_o), 32'd0);
        rst_i = 1'b1; sample_i = 8'd140; tick();
        chk("rstseq no strobe after reset", 32'(wr_inc_o), 32'd0);
        chk("rstseq no done after reset", 32'(done_o), 32'd0);
        chk("rstseq idle after reset", 32'(state_o), 32'd0);
        sample_valid_i = 1'b0; arm_i = 1'b1; tick();
        arm_i = 1'b0;
        chk("rstseq rearmed", 32'(state_o), 32'd1);
        strobes = 0; seen_done = 1'b0;
        sample_valid_i = 1'b1;
        for (int i = 0; i < 20 && !seen_done; i++) begin
            sample_i = (i == 0) ? 8'd50 : 8'(100 + i * 10);
            tick();
            strobes += int'(wr_inc_o);
            if (done_o) seen_done = 1'b1;
        end
        sample_valid_i = 1'b0;
        chk("rstseq done within budget", 32'(seen_done), 32'd1);
        chk("rstseq strobe count", 32'(strobes), 32'd4);
        chk("rstseq final state", 32'(state_o), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
